tx_frame_ctrl: RTL



---
 rtl/tx_pkg.sv | 34 +++
 rtl/tx_frame_ctrl_if.sv | 26 ++
 rtl/tx_byte_ser.sv | 49 ++++
 rtl/tx_frame_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit frame sequencer.
// Contents: FSM state encoding, header and frame-length bounds, and the length clamp helper.
// Used by: tx_frame_ctrl (FSM) and indirectly by the bench through the top module.
package tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_WAIT = 3'd2,
      ST_LOAD = 3'd3,
      ST_HDR  = 3'd4,
      ST_PAY  = 3'd5,
      ST_IFG  = 3'd6
   } tx_frame_state_t;

   localparam logic [13:0] HDR_BYTES     = 14'd14;
   localparam logic [13:0] MIN_FRAME_LEN = 14'd60;
   localparam logic [13:0] MAX_FRAME_LEN = 14'd16383;

   // Effective frame length: short requests are padded up to the minimum.
   // The upper bound is the full 14-bit range, so it is checked on a widened copy.
   function automatic logic [13:0] clamp_len(input logic [13:0] len);
      logic [15:0] wide;
      wide = {2'b00, len};
      if (wide < {2'b00, MIN_FRAME_LEN}) begin
         return MIN_FRAME_LEN;
      end
      if (wide > {2'b00, MAX_FRAME_LEN}) begin
         return MAX_FRAME_LEN;
      end
      return len;
   endfunction

endpackage

// File: rtl/tx_frame_ctrl_if.sv
// Byte stream interface between the frame sequencer and the FCS/preamble inserter.
// Signals: tx_data (8b), tx_valid, tx_sop, tx_eop from the source; tx_ready from the sink.
// A byte transfers on tx_valid && tx_ready; the source holds data and qualifiers while stalled.
interface tx_frame_ctrl_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_sop;
   logic       tx_eop;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      output tx_sop,
      output tx_eop,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      input  tx_sop,
      input  tx_eop,
      output tx_ready
   );
endinterface

// File: rtl/tx_byte_ser.sv
// Payload word serialiser: holds the current generator word and tracks which byte lane is up front.
// Latency: nxt_byte_o is combinational so the FSM can register it on the same edge as load/shift.
// Backpressure: state only moves on load_i/shift_i/last_i, so a stalled stream simply holds.
// Ports: clk, rst, load_i (capture data_i), shift_i (advance one byte), last_i (clear at frame end),
//        data_i (generator word), nxt_byte_o (byte to present next), idx_o (lane of front byte).
module tx_byte_ser (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        shift_i,
   input  logic        last_i,
   input  logic [31:0] data_i,
   output logic [7:0]  nxt_byte_o,
   output logic [1:0]  idx_o
);

   logic [31:0] sh_q;
   logic [1:0]  idx_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q  <= '0;
         idx_q <= '0;
      end else if (last_i) begin
         sh_q  <= '0;
         idx_q <= '0;
      end else if (load_i) begin
         sh_q  <= data_i;
         idx_q <= 2'd0;
      end else if (shift_i) begin
         sh_q  <= {sh_q[23:0], 8'h00};
         idx_q <= idx_q + 2'd1;
      end
   end

   // A load bypasses the register so the first byte of a new word follows
   // byte 3 of the previous one with no bubble.
   always_comb begin
      nxt_byte_o = sh_q[31:24];
      if (load_i) begin
         nxt_byte_o = data_i[31:24];
      end else if (shift_i) begin
         nxt_byte_o = sh_q[23:16];
      end
   end

   assign idx_o = idx_q;

endmodule

// File: rtl/tx_frame_ctrl.sv
// Transmit frame sequencer: seeds the payload generator, serialises 14-byte header + payload MSB first, then an IFG.
// Latency: start sampled in cycle 0, payload_pre in 1, first load in 3, SOP in 4, EOP at 3+length with tx_ready high.
// Backpressure: tx_valid/tx_ready; data, SOP and EOP hold while stalled; generator advances only on accepted byte 3.
// Ports: clk, rst (async, active-high); gen_en/start/frame_len/dst_mac/src_mac/eth_type/ifg_len request;
//        payload_pre/payload_valid/payload_data generator side; tx (byte stream master); busy.
// Optional: define TX_FRAME_STATS_EN to add frame_cnt (32b) and byte_cnt (48b) accepted-frame statistics.
module tx_frame_ctrl
   import tx_pkg::*;
#(
   parameter int unsigned DEF_IFG = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   gen_en,
   input  logic                   start,
   input  logic [13:0]            frame_len,
   input  logic [47:0]            dst_mac,
   input  logic [47:0]            src_mac,
   input  logic [15:0]            eth_type,
   input  logic [7:0]             ifg_len,
   output logic                   payload_pre,
   output logic                   payload_valid,
   input  logic [31:0]            payload_data,
   tx_frame_ctrl_if.master        tx,
`ifdef TX_FRAME_STATS_EN
   output logic [31:0]            frame_cnt,
   output logic [47:0]            byte_cnt,
`endif
   output logic                   busy
);

   tx_frame_state_t state_q;
   logic [13:0]     len_q;
   logic [13:0]     bcnt_q;     // index of the byte currently presented
   logic [7:0]      gap_q;
   logic [7:0]      ifg_cnt_q;
   logic [111:0]    hdr_q;      // front byte is always the next header byte to present
   logic [7:0]      tx_data_q;
   logic            tx_valid_q;
   logic            tx_sop_q;
   logic            tx_eop_q;
   logic            pre_q;
   logic            busy_q;

   logic            accept;
   logic            last_acc;
   logic            ser_load_d;
   logic            ser_shift_d;
   logic            ser_last_d;
   logic [7:0]      ser_nxt;
   logic [1:0]      ser_idx;

   assign accept   = tx_valid_q && tx.tx_ready;
   assign last_acc = accept && (bcnt_q == (len_q - 14'd1));

   // Serialiser controls. The word load after byte 3 happens on the accepting
   // edge itself, which is why payload_valid depends combinationally on tx_ready.
   always_comb begin
      ser_load_d  = 1'b0;
      ser_shift_d = 1'b0;
      ser_last_d  = 1'b0;
      case (state_q)
         ST_LOAD: ser_load_d = 1'b1;
         ST_PAY: begin
            if (accept) begin
               if (last_acc) begin
                  ser_last_d = 1'b1;
               end else if (ser_idx == 2'd3) begin
                  ser_load_d = 1'b1;
               end else begin
                  ser_shift_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   tx_byte_ser u_ser (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ser_load_d),
      .shift_i    (ser_shift_d),
      .last_i     (ser_last_d),
      .data_i     (payload_data),
      .nxt_byte_o (ser_nxt),
      .idx_o      (ser_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         bcnt_q     <= '0;
         gap_q      <= '0;
         ifg_cnt_q  <= '0;
         hdr_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         tx_sop_q   <= 1'b0;
         tx_eop_q   <= 1'b0;
         pre_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         pre_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start && gen_en) begin
                  len_q   <= clamp_len(frame_len);
                  hdr_q   <= {dst_mac, src_mac, eth_type};
                  gap_q   <= (ifg_len == 8'd0) ? 8'(DEF_IFG) : ifg_len;
                  bcnt_q  <= '0;
                  pre_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= ST_PREP;
               end
            end
            ST_PREP: state_q <= ST_WAIT;
            // The generator needs a cycle after the seed before its first word is valid.
            ST_WAIT: state_q <= ST_LOAD;
            ST_LOAD: begin
               tx_valid_q <= 1'b1;
               tx_sop_q   <= 1'b1;
               tx_eop_q   <= 1'b0;
               tx_data_q  <= hdr_q[111:104];
               hdr_q      <= {hdr_q[103:0], 8'h00};
               state_q    <= ST_HDR;
            end
            ST_HDR: begin
               if (accept) begin
                  tx_sop_q <= 1'b0;
                  bcnt_q   <= bcnt_q + 14'd1;
                  if (bcnt_q == (HDR_BYTES - 14'd1)) begin
                     tx_data_q <= ser_nxt;
                     state_q   <= ST_PAY;
                  end else begin
                     tx_data_q <= hdr_q[111:104];
                     hdr_q     <= {hdr_q[103:0], 8'h00};
                  end
               end
            end
            ST_PAY: begin
               if (accept) begin
                  if (last_acc) begin
                     tx_valid_q <= 1'b0;
                     tx_eop_q   <= 1'b0;
                     tx_data_q  <= '0;
                     bcnt_q     <= '0;
                     ifg_cnt_q  <= gap_q;
                     state_q    <= ST_IFG;
                  end else begin
                     tx_data_q <= ser_nxt;
                     bcnt_q    <= bcnt_q + 14'd1;
                     tx_eop_q  <= ((bcnt_q + 14'd2) == len_q);
                  end
               end
            end
            ST_IFG: begin
               if (ifg_cnt_q <= 8'd1) begin
                  ifg_cnt_q <= '0;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end else begin
                  ifg_cnt_q <= ifg_cnt_q - 8'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef TX_FRAME_STATS_EN
   logic [31:0] frame_cnt_q;
   logic [47:0] byte_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= '0;
         byte_cnt_q  <= '0;
      end else if (last_acc) begin
         frame_cnt_q <= frame_cnt_q + 32'd1;
         byte_cnt_q  <= byte_cnt_q + {34'd0, len_q};
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign byte_cnt  = byte_cnt_q;
`endif

   assign payload_pre   = pre_q;
   assign payload_valid = ser_load_d;
   assign busy          = busy_q;
   assign tx.tx_data    = tx_data_q;
   assign tx.tx_valid   = tx_valid_q;
   assign tx.tx_sop     = tx_sop_q;
   assign tx.tx_eop     = tx_eop_q;

endmodule
